axi_mem_slave: RTL and testbench
================================

// Module: axi_mem_slave
// PURPOSE
//  Word-addressed memory model/controller on the far side of the core's AXI pins.
//  Consumes the AW/W/B and AR/R traffic from the core's memory arbiter and serves
//  incrementing bursts of ARLEN+1 / AWLEN+1 beats. One outstanding read plus one
//  outstanding write at a time; read and write engines run independently.
// PARAMETERS
//  ADDR_WIDTH    26  byte-address width, equal to `ADDR_WIDTH
//  DATA_WIDTH    32  beat width, equal to `DATA_WIDTH
//  DEPTH_LOG2    16  log2 of array depth in words
//  READ_LATENCY  4   cycles from AR handshake to first RVALID (>=1)
// PORTS
//  clk      in   1           clock
//  rst      in   1           synchronous reset, active-high
//  AWREADY  out  1           write address accept
//  AWVALID  in   1           write address valid
//  AWID     in   4           write id
//  AWLEN    in   4           write beats minus 1
//  AWADDR   in   ADDR_WIDTH  write start byte address
//  WREADY   out  1           write data accept
//  WVALID   in   1           write data valid
//  WLAST    in   1           master's last-beat marker
//  WID      in   4           write data id (ignored)
//  WDATA    in   DATA_WIDTH  write data
//  BVALID   out  1           write response valid
//  BREADY   in   1           write response accept
//  BID      out  4           echoes latched AWID
//  ARREADY  out  1           read address accept
//  ARVALID  in   1           read address valid
//  ARID     in   4           read id
//  ARLEN    in   4           read beats minus 1
//  ARADDR   in   ADDR_WIDTH  read start byte address
//  RREADY   in   1           read data accept
//  RVALID   out  1           read data valid
//  RLAST    out  1           final read beat
//  RID      out  4           echoes latched ARID
//  RDATA    out  DATA_WIDTH  read data
//  wlast_err out 1           sticky: WLAST disagreed with beat count
// BEHAVIOUR
//  Reset: ARREADY=AWREADY=1; RVALID=RLAST=WREADY=BVALID=wlast_err=0; RID=BID=RDATA=0.
//   Array contents are not cleared. Reset mid-burst drops the burst; no beat completes.
//  Word index = addr[2 +: DEPTH_LOG2]. Addr[1:0] ignored. Index increments per beat
//   and wraps modulo 2**DEPTH_LOG2.
//  Read FSM R_IDLE -> R_WAIT -> R_BURST -> R_IDLE:
//   R_IDLE: ARREADY=1. On ARVALID: latch ARID/ARLEN/index, load cnt=READ_LATENCY-1,
//    go to R_WAIT, ARREADY=0 the next cycle.
//   R_WAIT: cnt decrements each cycle. At cnt==0, the next cycle enters R_BURST with
//    RVALID=1. First beat appears READ_LATENCY cycles after the AR handshake.
//   R_BURST: RVALID held with RDATA/RID stable until RREADY. On handshake, advance
//    index and beat count. RLAST=1 on beat ARLEN. Handshake on RLAST -> R_IDLE.
//    One beat per cycle while RREADY is held high.
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   W_IDLE: AWREADY=1. On AWVALID: latch AWID/AWLEN/index, go to W_DATA.
//   W_DATA: WREADY=1. Each WVALID cycle writes WDATA at index, then index++.
//    After AWLEN+1 beats: go to W_RESP, WREADY=0.
//    The burst length is set by AWLEN only. If WLAST is asserted on any beat other
//    than beat AWLEN, or deasserted on beat AWLEN, set wlast_err (cleared only by rst).
//   W_RESP: BVALID=1 with BID until BREADY, then -> W_IDLE.
//  Simultaneous events:
//   AR and AW in the same cycle are both accepted.
//   Same-cycle R beat and W beat to one index: R returns pre-write data.
//   A write that completes before an R beat is presented is visible to that beat.
//   RDATA is combinational from the array at the current read index.
//  Unaffected by the core's hazard control. Any stall is expressed only through
//   RREADY and BREADY.
// TESTING
//  1) Preload mem[0x10]=0xDEADBEEF; AR addr=0x40 len=0, RREADY=1 -> RVALID 4 cycles
//     after AR, RDATA=0xDEADBEEF, RLAST=1, RID=ARID.
//  2) AW addr=0x100 len=3 id=5; W beats 1,2,3,4 with WLAST on beat 4 -> mem[0x40..0x43]=1..4,
//     BVALID with BID=5, wlast_err=0; then a read burst len=3 returns 1,2,3,4.
//  3) Read burst len=3 with RREADY toggling 1,0,1,0 -> each beat held stable while
//     RREADY=0, exactly 4 handshakes, RLAST only on the 4th.
//  4) Write len=1 with WLAST on beat 0 -> 2 beats written, wlast_err=1, stays 1 until rst.
//  5) Read at word index 2**DEPTH_LOG2-1 with len=1 -> second beat returns mem[0] (wrap).
//  6) Assert rst during R_BURST beat 2 of 4 -> next cycle RVALID=0, ARREADY=1;
//     a fresh AR is served normally and array data is intact.

Source files
------------

// File: rtl/axi_mem_slave.sv
// Word-addressed AXI memory model with independent read and write burst engines.
// Latency: first R beat READ_LATENCY cycles after AR handshake; B one cycle after the last W beat.
// Backpressure: RREADY stalls the read burst, BREADY holds the write response; AR/AW blocked while busy.
module axi_mem_slave #(
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 16,
    parameter int READ_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  AWREADY,
    input  logic                  AWVALID,
    input  logic [3:0]            AWID,
    input  logic [3:0]            AWLEN,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  WREADY,
    input  logic                  WVALID,
    input  logic                  WLAST,
    input  logic [3:0]            WID,
    input  logic [DATA_WIDTH-1:0] WDATA,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [3:0]            BID,
    output logic                  ARREADY,
    input  logic                  ARVALID,
    input  logic [3:0]            ARID,
    input  logic [3:0]            ARLEN,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  RREADY,
    output logic                  RVALID,
    output logic                  RLAST,
    output logic [3:0]            RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  wlast_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_BURST
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    r_state_t              r_state, r_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [3:0]            r_len;
    logic [3:0]            r_beat;
    logic [3:0]            r_id;

    w_state_t              w_state, w_state_nxt;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [3:0]            w_len;
    logic [3:0]            w_beat;
    logic [3:0]            w_id;
    logic                  w_beat_fire;
    logic                  w_last_beat;
    logic                  mem_we;

    // Low address bits, bits above the array and WID carry no meaning here.
    logic unused_in;
    assign unused_in = ^{WID, AWADDR, ARADDR};

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ARVALID) r_state_nxt = R_WAIT;
            R_WAIT:  if (r_cnt == '0) r_state_nxt = R_BURST;
            R_BURST: if (RREADY && (r_beat == r_len)) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_id    <= '0;
        end else begin
            r_state <= r_state_nxt;
            case (r_state)
                R_IDLE: begin
                    if (ARVALID) begin
                        r_id   <= ARID;
                        r_len  <= ARLEN;
                        r_idx  <= ARADDR[2 +: DEPTH_LOG2];
                        r_beat <= '0;
                        r_cnt  <= CNT_LOAD;
                    end
                end
                R_WAIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                R_BURST: begin
                    if (RREADY) begin
                        r_idx  <= r_idx + 1'b1;
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ARREADY = (r_state == R_IDLE);
    assign RVALID  = (r_state == R_BURST);
    assign RLAST   = RVALID && (r_beat == r_len);
    assign RID     = r_id;
    // Array read is combinational so a same-cycle write to this index is not yet visible.
    assign RDATA   = RVALID ? mem[r_idx] : '0;

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    assign w_beat_fire = (w_state == W_DATA) && WVALID;
    assign w_last_beat = (w_beat == w_len);

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (AWVALID) w_state_nxt = W_DATA;
            W_DATA:  if (WVALID && w_last_beat) w_state_nxt = W_RESP;
            W_RESP:  if (BREADY) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            w_idx     <= '0;
            w_len     <= '0;
            w_beat    <= '0;
            w_id      <= '0;
            wlast_err <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (w_state == W_IDLE && AWVALID) begin
                w_id   <= AWID;
                w_len  <= AWLEN;
                w_idx  <= AWADDR[2 +: DEPTH_LOG2];
                w_beat <= '0;
            end
            if (w_beat_fire) begin
                w_idx  <= w_idx + 1'b1;
                w_beat <= w_beat + 1'b1;
                // Burst length comes from AWLEN; WLAST is only cross-checked.
                if (WLAST != w_last_beat) wlast_err <= 1'b1;
            end
        end
    end

    // Gated by rst so a burst cut short by reset leaves no partial beat behind.
    assign mem_we = w_beat_fire && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) mem[w_idx] <= WDATA;
    end

    assign AWREADY = (w_state == W_IDLE);
    assign WREADY  = (w_state == W_DATA);
    assign BVALID  = (w_state == W_RESP);
    assign BID     = w_id;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Bench for axi_mem_slave: randomized AXI bursts against an array reference model,
// with a negedge monitor popping expected R/B responses from scoreboard queues.
module tb_axi_mem_slave;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int DL = 16;
    localparam int RL = 4;
    localparam int NW = 1 << DL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, wlast_err;
    logic          AWVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0, BREADY = 1'b0;
    logic          ARVALID = 1'b0, RREADY = 1'b0;
    logic [3:0]    AWID = '0, AWLEN = '0, WID = '0, ARID = '0, ARLEN = '0;
    logic [3:0]    BID, RID;
    logic [AW-1:0] AWADDR = '0, ARADDR = '0;
    logic [DW-1:0] WDATA = '0, RDATA;

    always #5 clk = ~clk;

    axi_mem_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .AWREADY(AWREADY), .AWVALID(AWVALID), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
        .WREADY(WREADY), .WVALID(WVALID), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
        .ARREADY(ARREADY), .ARVALID(ARVALID), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
        .RREADY(RREADY), .RVALID(RVALID), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
        .wlast_err(wlast_err)
    );

    typedef struct {
        logic [31:0] dat;
        logic [3:0]  id;
        logic        last;
    } rexp_t;

    rexp_t       rq[$];
    logic [3:0]  bq[$];
    int          lat_q[$];
    logic [31:0] mm [0:NW-1];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int r_hs = 0;
    int r_pushed = 0;
    int rready_mode = 0;
    bit mon_en = 1'b0;
    bit prev_rvalid = 1'b0;
    bit exp_wlast_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_chk++;
        n_err++;
        $display("FAIL %s: %s", name, why);
    endtask

    function automatic logic [AW-1:0] mk_addr(input int idx);
        logic [7:0]  hi = 8'($urandom);
        logic [1:0]  lo = 2'($urandom);
        logic [15:0] wi = 16'(idx);
        return {hi, wi, lo};
    endfunction

    // Ready drivers: RREADY pattern selected by rready_mode, BREADY random.
    always @(posedge clk) begin
        #1;
        case (rready_mode)
            0:       RREADY = 1'b1;
            1:       RREADY = ($urandom_range(0, 3) != 0);
            default: RREADY = ~RREADY;
        endcase
        BREADY = ($urandom_range(0, 2) != 0);
    end

    // Monitor: compares every presented R beat against the queue head, pops on handshake.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (RVALID) begin
                if (!prev_rvalid) begin
                    if (lat_q.size() == 0) fail_now("r_latency", "RVALID with no read issued");
                    else chk("r_latency", cyc, lat_q.pop_front());
                end
                if (rq.size() == 0) begin
                    fail_now("r_beat", "unexpected read beat");
                end else begin
                    chk("rdata", RDATA, rq[0].dat);
                    chk("rid", RID, rq[0].id);
                    chk("rlast", RLAST, rq[0].last);
                    if (RREADY) begin
                        void'(rq.pop_front());
                        r_hs++;
                    end
                end
            end
            prev_rvalid = RVALID;
            if (BVALID && BREADY) begin
                if (bq.size() == 0) fail_now("bid", "unexpected write response");
                else chk("bid", BID, bq.pop_front());
            end
        end
    end

    // Waits (bounded) until the channel's ready is seen, then completes the handshake edge.
    task automatic wait_ready(input int ch, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((ch == 0 && AWREADY) || (ch == 1 && WREADY) || (ch == 2 && ARREADY)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now(name, "timed out waiting for ready");
        @(posedge clk);
        #1;
    endtask

    // dmode: 0 random data, 1 sequence 1..n, 2 constant 0xDEADBEEF. bad_last<0 means correct WLAST.
    task automatic do_write(input int idx, input int len, input logic [3:0] id,
                            input int dmode, input int bad_last);
        logic [31:0] d;
        bit          last;
        @(posedge clk);
        #1;
        AWADDR  = mk_addr(idx);
        AWID    = id;
        AWLEN   = 4'(len);
        AWVALID = 1'b1;
        bq.push_back(id);
        wait_ready(0, "aw_handshake");
        AWVALID = 1'b0;
        for (int b = 0; b <= len; b++) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
            d = (dmode == 1) ? 32'(b + 1) : (dmode == 2) ? 32'hDEADBEEF : $urandom;
            last = (bad_last < 0) ? (b == len) : (b == bad_last);
            if (last != (b == len)) exp_wlast_err = 1'b1;
            mm[16'(idx + b)] = d;
            WDATA  = d;
            WLAST  = last;
            WID    = id;
            WVALID = 1'b1;
            wait_ready(1, "w_handshake");
            WVALID = 1'b0;
            WLAST  = 1'b0;
        end
        for (int i = 0; i < 300 && bq.size() != 0; i++) @(negedge clk);
        if (bq.size() != 0) fail_now("b_resp", "timed out waiting for BVALID");
    endtask

    task automatic do_read(input int idx, input int len, input logic [3:0] id);
        rexp_t e;
        @(posedge clk);
        #1;
        for (int b = 0; b <= len; b++) begin
            e.dat  = mm[16'(idx + b)];
            e.id   = id;
            e.last = (b == len);
            rq.push_back(e);
            r_pushed++;
        end
        ARADDR  = mk_addr(idx);
        ARID    = id;
        ARLEN   = 4'(len);
        ARVALID = 1'b1;
        wait_ready(2, "ar_handshake");
        ARVALID = 1'b0;
        lat_q.push_back(cyc + RL);
        for (int i = 0; i < 500 && rq.size() != 0; i++) @(negedge clk);
        if (rq.size() != 0) fail_now("r_burst", "timed out waiting for read beats");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int n;
        bit got;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", ARREADY, 1);
        chk("rst_awready", AWREADY, 1);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_wlast_err", wlast_err, 0);
        chk("rst_rid", RID, 0);
        chk("rst_bid", BID, 0);
        chk("rst_rdata", RDATA, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Preload the regions the random phase touches, including the top of the array.
        for (int k = 0; k < 4; k++) do_write(k * 16, 15, 4'($urandom), 0, -1);
        do_write(NW - 16, 15, 4'($urandom), 0, -1);

        // Single-beat read of a known word; latency checked by the monitor.
        do_write(16'h10, 0, 4'h3, 2, -1);
        do_read(16'h10, 0, 4'hA);

        // Four-beat write of 1..4 at byte 0x100, then read it back.
        do_write(16'h40, 3, 4'h5, 1, -1);
        chk("t2_wlast_err", wlast_err, exp_wlast_err);
        do_read(16'h40, 3, 4'h2);

        // RREADY toggling: beats must hold until accepted, exactly four handshakes.
        rready_mode = 2;
        h0 = r_hs;
        do_read(16'h20, 3, 4'h7);
        chk("t3_handshakes", r_hs - h0, 4);
        rready_mode = 0;

        // Read starting at the last word wraps to word 0.
        do_read(NW - 1, 1, 4'hC);

        // Concurrent random reads and writes to disjoint regions.
        for (int it = 0; it < 30; it++) begin
            int ri, rlen, wi, wlen;
            ri   = ($urandom_range(0, 3) == 0) ? (NW - 16 + $urandom_range(0, 15)) : $urandom_range(0, 15);
            rlen = $urandom_range(0, 15);
            wi   = $urandom_range(32, 47);
            wlen = $urandom_range(0, 15);
            rready_mode = $urandom_range(0, 1);
            fork
                do_read(ri, rlen, 4'($urandom));
                do_write(wi, wlen, 4'($urandom), 0, -1);
            join
        end
        rready_mode = 0;
        chk("rand_wlast_err", wlast_err, exp_wlast_err);
        do_read(32, 15, 4'h1);
        do_read(48, 15, 4'h4);

        // WLAST on the wrong beat: both beats still written, error flag sticks.
        do_write(100, 1, 4'h6, 0, 0);
        chk("t4_wlast_err", wlast_err, exp_wlast_err);
        do_read(100, 1, 4'h8);
        chk("t4_wlast_err_sticky", wlast_err, exp_wlast_err);

        // Reset in the middle of a four-beat read.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        ARADDR  = mk_addr(0);
        ARID    = 4'h9;
        ARLEN   = 4'd3;
        ARVALID = 1'b1;
        wait_ready(2, "t6_ar_handshake");
        ARVALID = 1'b0;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (RVALID) begin
                if (n == 2) begin
                    got = 1'b1;
                    break;
                end
                n++;
            end
        end
        if (!got) fail_now("t6_beat2", "third beat never presented");
        chk("t6_beat2_data", RDATA, mm[2]);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rvalid", RVALID, 0);
        chk("t6_arready", ARREADY, 1);
        chk("t6_rlast", RLAST, 0);
        exp_wlast_err = 1'b0;
        chk("t6_wlast_err", wlast_err, exp_wlast_err);
        rst = 1'b0;
        rq.delete();
        lat_q.delete();
        prev_rvalid = 1'b0;
        mon_en = 1'b1;
        do_read(0, 3, 4'hB);
        do_read(NW - 16, 15, 4'hD);

        chk("r_beat_count", r_hs, r_pushed);
        chk("rq_empty", rq.size(), 0);
        chk("bq_empty", bq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
